sfx_i2s_player: RTL and testbench

Parametrised multi-channel sound-effect player and serial DAC driver for the WM8731 audio path. It runs from a single system clock and derives BCLK and LRCK internally as divided outputs, so no PLL is needed. Up to NUM_SFX external sample ROMs are read, one address per frame each, with per-channel one-shot or gated playback and restart-on-retrigger. Active channels are mixed with saturation and shifted out MSB-first in DSP mode A. It sits between game logic (triggers) and the codec pins, after I2C configuration has completed.

---
 rtl/sfx_pkg.sv | 11 +
 rtl/sfx_channel.sv | 57 +++++
 rtl/sfx_i2s_player.sv | 98 +++++++++
 tb/tb_sfx_i2s_player.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared channel state type and saturating mix helper for the SFX player
package sfx_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, HOLD} chan_state_e;
    function automatic logic signed [31:0] sat_mix(input logic signed [31:0] sum, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        return (sum > hi) ? hi : ((sum < lo) ? lo : sum);
    endfunction
endpackage

// File: rtl/sfx_channel.sv
// sfx_channel: trigger edge detect, playback FSM and ROM address counter for one effect
module sfx_channel
    import sfx_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter bit GATED  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fb,
    input  logic              trig,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
);
    chan_state_e state;
    logic trig_q, pend, req;
    // a rising edge in the frame-boundary cycle itself still counts for that boundary
    assign req = pend | (trig & ~trig_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            busy   <= 1'b0;
            trig_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            trig_q <= trig;
            if (!en) begin
                state <= IDLE;
                addr  <= '0;
                busy  <= 1'b0;
                pend  <= 1'b0;
            end else if (!fb) begin
                pend <= req;
            end else begin
                pend <= 1'b0;
                if (GATED && !trig) begin
                    state <= IDLE;
                    addr  <= '0;
                    busy  <= 1'b0;
                end else if (GATED ? state == IDLE : req) begin
                    state <= PLAY;
                    addr  <= '0;
                    busy  <= 1'b1;
                end else if (state == PLAY && addr < last) begin
                    addr <= addr + ADDR_W'(1);
                end else if (state == PLAY) begin
                    state <= GATED ? HOLD : IDLE;
                    addr  <= GATED ? addr : '0;
                    busy  <= GATED;
                end
            end
        end
    end
endmodule

// File: rtl/sfx_i2s_player.sv
// sfx_i2s_player: multi-channel SFX ROM player with saturating mono mix and DSP-mode-A DAC serialiser
module sfx_i2s_player
    import sfx_pkg::*;
#(
    parameter int                 NUM_SFX    = 3,
    parameter int                 SAMPLE_W   = 16,
    parameter int                 ADDR_W     = 18,
    parameter int                 BCLK_DIV   = 4,
    parameter int                 SLOT_W     = 32,
    parameter logic [NUM_SFX-1:0] GATED_MASK = 3'b011
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_SFX-1:0]           trig,
    input  logic [NUM_SFX*ADDR_W-1:0]    sfx_last,
    output logic [NUM_SFX*ADDR_W-1:0]    rom_addr,
    output logic [NUM_SFX-1:0]           rom_rden,
    input  logic [NUM_SFX*SAMPLE_W-1:0]  rom_q,
    output logic [NUM_SFX-1:0]           busy,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         dac_data
);
    localparam int FRAME_BCLKS = 2 * SLOT_W;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FRAME_BCLKS);
    localparam int MW = SAMPLE_W + 3;
    logic [1:0] rst_sync;
    logic rst_n, run, fb, bit_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [BW-1:0] bidx, bidx_n;
    logic signed [MW-1:0] sum;
    logic [SAMPLE_W-1:0] mix, tx;
    logic [SLOT_W-1:0] slot;
    logic [FRAME_BCLKS-1:0] frame_bits;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];
    assign fb = en && run && dcnt == DW'(BCLK_DIV - 1) && bidx == BW'(FRAME_BCLKS - 1);
    assign rom_rden = busy;
    for (genvar i = 0; i < NUM_SFX; i++) begin : g_ch
        sfx_channel #(.ADDR_W(ADDR_W), .GATED(GATED_MASK[i])) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .fb   (fb),
            .trig (trig[i]),
            .last (sfx_last[i*ADDR_W +: ADDR_W]),
            .addr (rom_addr[i*ADDR_W +: ADDR_W]),
            .busy (busy[i])
        );
    end
    // each slot is a zero bit, the sample MSB-first, then zero padding; both slots carry the mono mix
    assign slot = SLOT_W'({1'b0, tx}) << (SLOT_W - SAMPLE_W - 1);
    assign frame_bits = {slot, slot};
    always_comb begin
        dcnt_n = (dcnt == DW'(BCLK_DIV - 1)) ? '0 : dcnt + DW'(1);
        bidx_n = (dcnt != DW'(BCLK_DIV - 1)) ? bidx : (bidx == BW'(FRAME_BCLKS - 1)) ? '0 : bidx + BW'(1);
        bit_n = frame_bits[BW'(FRAME_BCLKS - 1) - bidx_n];
        sum = '0;
        for (int i = 0; i < NUM_SFX; i++)
            if (busy[i]) sum = sum + MW'(signed'(rom_q[i*SAMPLE_W +: SAMPLE_W]));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            dcnt     <= DW'(BCLK_DIV - 1);
            bidx     <= BW'(FRAME_BCLKS - 1);
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            dac_data <= 1'b0;
            mix      <= '0;
            tx       <= '0;
        end else if (!en) begin
            run      <= 1'b0;
            dcnt     <= DW'(BCLK_DIV - 1);
            bidx     <= BW'(FRAME_BCLKS - 1);
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            dac_data <= 1'b0;
            mix      <= '0;
            tx       <= '0;
        end else begin
            run      <= 1'b1;
            dcnt     <= dcnt_n;
            bidx     <= bidx_n;
            bclk     <= dcnt_n >= DW'(BCLK_DIV / 2);
            lrclk    <= bidx_n == '0;
            dac_data <= bit_n;
            // rom_q for the addresses issued at the boundary is valid one clk later
            if (dcnt == DW'(1) && bidx == '0) mix <= SAMPLE_W'(sat_mix(32'(sum), SAMPLE_W));
            if (fb) tx <= mix;
        end
    end
endmodule

// File: tb/tb_sfx_i2s_player.sv
// tb_sfx_i2s_player: random and directed stimulus, frame-level reference model and serial-stream scoreboard
`timescale 1ns/1ps
module tb_sfx_i2s_player;
    localparam int N = 3;
    localparam int SW = 16;
    localparam int AW = 18;
    localparam int DIV = 4;
    localparam int SLOT = 32;
    localparam int FCLK = DIV * 2 * SLOT;
    localparam logic [N-1:0] GM = 3'b011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic [N-1:0] trig = '0;
    logic [N*AW-1:0] sfx_last = '0;
    logic [N*AW-1:0] rom_addr;
    logic [N-1:0] rom_rden, busy;
    logic [N*SW-1:0] rom_q;
    logic bclk, lrclk, dac_data;

    logic [SW-1:0] rom [N][8];
    int checks = 0;
    int passed = 0;

    // reference model state
    int pos = -1;
    logic [N-1:0] act = '0, hold = '0, pend = '0, trig_prev = '0;
    int idx [N];
    logic [SW-1:0] next_val = '0;
    logic [SW-1:0] exp_q [$];

    // monitor state
    logic lr_prev = 1'b0, bc_prev = 1'b0, in_frame = 1'b0, pad_err = 1'b0;
    int bi = 0, ferr = 0;
    logic [SW-1:0] lw, rw, e;

    always #5 clk = ~clk;

    sfx_i2s_player #(
        .NUM_SFX(N), .SAMPLE_W(SW), .ADDR_W(AW), .BCLK_DIV(DIV), .SLOT_W(SLOT), .GATED_MASK(GM)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .trig(trig), .sfx_last(sfx_last),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q), .busy(busy),
        .bclk(bclk), .lrclk(lrclk), .dac_data(dac_data)
    );

    always @(posedge clk)
        for (int i = 0; i < N; i++) rom_q[i*SW +: SW] <= rom[i][rom_addr[i*AW +: 3]];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic int lastv(input int i);
        return int'(sfx_last[i*AW +: AW]);
    endfunction

    function automatic logic [SW-1:0] model_mix();
        int s = 0;
        for (int i = 0; i < N; i++) if (act[i]) s += int'($signed(rom[i][idx[i]]));
        return (s > 32767) ? 16'h7fff : (s < -32768) ? 16'h8000 : 16'(s);
    endfunction

    function automatic void frame_step();
        for (int i = 0; i < N; i++) begin
            if (GM[i]) begin
                if (!trig[i]) begin act[i] = 0; hold[i] = 0; idx[i] = 0; end
                else if (!act[i]) begin act[i] = 1; idx[i] = 0; end
                else if (!hold[i]) begin
                    if (idx[i] < lastv(i)) idx[i]++;
                    else hold[i] = 1;
                end
            end else if (pend[i]) begin
                act[i] = 1; idx[i] = 0;
            end else if (act[i]) begin
                if (idx[i] < lastv(i)) idx[i]++;
                else begin act[i] = 0; idx[i] = 0; end
            end
            pend[i] = 0;
        end
    endfunction

    // the frame starting at each boundary carries the mix of the addresses issued one boundary earlier
    always @(posedge clk) begin
        if (!en) begin
            pos = -1;
            exp_q.delete();
            next_val = '0;
            act = '0; hold = '0; pend = '0;
            for (int i = 0; i < N; i++) idx[i] = 0;
        end else begin
            pos++;
            for (int i = 0; i < N; i++) if (trig[i] && !trig_prev[i]) pend[i] = 1;
            if (pos % FCLK == 0) begin
                exp_q.push_back(next_val);
                if (pos > 0) frame_step();
                next_val = model_mix();
            end
        end
        trig_prev = trig;
    end

    always @(negedge clk) begin
        if (!en || pos < 0) begin
            in_frame = 0; lr_prev = 0; bc_prev = 0; ferr = 0;
        end else begin
            if (bclk !== ((pos % DIV) >= DIV / 2) || lrclk !== ((pos % FCLK) < DIV)) ferr++;
            if (pos % FCLK == FCLK - 1) begin
                check("framing", 64'(ferr), 64'(0));
                ferr = 0;
            end
            if (pos % FCLK == FCLK / 2) begin
                check("busy", 64'(busy), 64'(act));
                check("rom_rden", 64'(rom_rden), 64'(act));
                for (int i = 0; i < N; i++) check("rom_addr", 64'(rom_addr[i*AW +: AW]), 64'(idx[i]));
            end
            if (lrclk && !lr_prev) begin
                in_frame = 1; bi = -1; lw = '0; rw = '0; pad_err = 0;
            end
            if (bclk && !bc_prev && in_frame) begin
                bi++;
                if (bi >= 1 && bi <= SW) lw = {lw[SW-2:0], dac_data};
                else if (bi >= SLOT + 1 && bi <= SLOT + SW) rw = {rw[SW-2:0], dac_data};
                else pad_err = pad_err | dac_data;
                if (bi == 2 * SLOT - 1) begin
                    in_frame = 0;
                    if (exp_q.size() == 0) check("scoreboard_empty", 64'(1), 64'(0));
                    else begin
                        e = exp_q.pop_front();
                        check("left", 64'(lw), 64'(e));
                        check("right", 64'(rw), 64'(e));
                        check("pad", 64'(pad_err), 64'(0));
                    end
                end
            end
            lr_prev = lrclk;
            bc_prev = bclk;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (!(pos >= 0 && pos % FCLK == p) && k < 2 * FCLK) begin tick(1); k++; end
        if (k >= 2 * FCLK) check("wait_pos_timeout", 64'(1), 64'(0));
    endtask

    task automatic pulse(input int ch);
        trig[ch] = 1'b1;
        tick(1);
        trig[ch] = 1'b0;
    endtask

    task automatic set_last(input int ch, input int v);
        sfx_last[ch*AW +: AW] = AW'(v);
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) rom[i][j] = '0;
        #2 reset = 1'b0;
        tick(4);
        check("reset_outputs", 64'({bclk, lrclk, dac_data, busy, rom_rden, |rom_addr}), 64'(0));
        reset = 1'b1;
        tick(5);
        en = 1'b1;
        tick(2 * FCLK);
        // one-shot on channel 2
        rom[2][0] = 16'h1000; rom[2][1] = 16'h2000; rom[2][2] = 16'h3000; rom[2][3] = 16'h4000;
        set_last(2, 3);
        wait_pos(60);
        pulse(2);
        tick(6 * FCLK);
        // retrigger while addr is 2
        wait_pos(60);
        pulse(2);
        k = 0;
        while (!(act[2] && idx[2] == 2) && k < 4 * FCLK) begin tick(1); k++; end
        if (k >= 4 * FCLK) check("retrig_wait_timeout", 64'(1), 64'(0));
        wait_pos(80);
        pulse(2);
        tick(7 * FCLK);
        // gated channel 0
        rom[0][0] = 16'h0123; rom[0][1] = 16'h0456;
        set_last(0, 1);
        wait_pos(30);
        trig[0] = 1'b1;
        tick(5 * FCLK);
        trig[0] = 1'b0;
        tick(3 * FCLK);
        // saturation, positive then negative
        rom[0][0] = 16'h7000; rom[1][0] = 16'h6000;
        set_last(0, 0); set_last(1, 0);
        wait_pos(30);
        trig[1:0] = 2'b11;
        tick(3 * FCLK);
        trig[1:0] = 2'b00;
        tick(2 * FCLK);
        rom[0][0] = 16'h9000; rom[1][0] = 16'h9000;
        trig[1:0] = 2'b11;
        tick(3 * FCLK);
        trig[1:0] = 2'b00;
        tick(2 * FCLK);
        // randomized play with random contents and lengths
        for (int i = 0; i < N; i++) begin
            set_last(i, int'($urandom_range(7)));
            for (int j = 0; j < 8; j++) rom[i][j] = 16'($urandom);
        end
        for (int c = 0; c < 40 * FCLK; c++) begin
            trig[2] = ($urandom_range(399) == 0);
            for (int i = 0; i < 2; i++) if ($urandom_range(299) == 0) trig[i] = ~trig[i];
            tick(1);
        end
        trig = '0;
        tick(3 * FCLK);
        // en drop mid-frame while channel 2 plays
        set_last(2, 7);
        wait_pos(10);
        pulse(2);
        tick(FCLK);
        wait_pos(100);
        en = 1'b0;
        tick(1);
        check("en_drop_outputs", 64'({bclk, lrclk, dac_data, rom_rden, |rom_addr}), 64'(0));
        check("en_drop_busy", 64'(busy), 64'(0));
        tick(20);
        en = 1'b1;
        tick(4 * FCLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
